hmc_tx_flit_unpacker: RTL



---
 rtl/hmc_tx_flit_unpacker.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/hmc_tx_flit_unpacker.sv
// hmc_tx_flit_unpacker
// Splits PHY TX words into flits, drops NULL flits between packets, delineates
// packets by the header LNG field and streams flits out one per cycle with
// sop/eop markers through a small flit FIFO.
// Optional build macro: HMC_TX_UNPACK_STATS_EN adds pkt_count / null_count.
module hmc_tx_flit_unpacker #(
    parameter int DWIDTH     = 512,
    parameter int FPW        = 4,
    parameter int FLIT_SIZE  = 128,
    parameter int FIFO_DEPTH = 32
) (
    input  logic                 clk,
    input  logic                 res_n,
    input  logic [DWIDTH-1:0]    phy_data_tx_link2phy,
    input  logic                 phy_word_valid,
    output logic                 phy_word_ready,
    output logic [FLIT_SIZE-1:0] flit_data,
    output logic                 flit_valid,
    output logic                 flit_sop,
    output logic                 flit_eop,
    input  logic                 flit_ready,
    output logic                 lng_error,
    output logic                 fifo_overflow
`ifdef HMC_TX_UNPACK_STATS_EN
    ,
    output logic [31:0]          pkt_count,
    output logic [31:0]          null_count
`endif
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam int EW = FLIT_SIZE + 2;

    typedef enum logic {HDR, BODY} state_t;

    state_t         state_q, state_d;
    logic [3:0]     rem_q, rem_d;
    logic [EW-1:0]  mem_q [FIFO_DEPTH];
    logic [PW-1:0]  wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]  count_q, count_d;
    logic           ready_q;
    logic           lng_err_q, lng_err_d;
    logic           ovf_q;

    logic           accept;
    logic           pop;
    logic [CW-1:0]  push_cnt;
    logic [FPW-1:0] push_en;
    logic [FPW-1:0] ent_sop;
    logic [FPW-1:0] ent_eop;
    logic [PW-1:0]  slot [FPW];
    logic [EW-1:0]  head;

`ifdef HMC_TX_UNPACK_STATS_EN
    logic [CW-1:0]  null_cnt;
    logic [CW-1:0]  sop_cnt;
    logic [31:0]    pkt_count_q;
    logic [31:0]    null_count_q;
`endif

    assign accept = phy_word_valid && ready_q;
    assign flit_valid = (count_q != '0);
    assign pop = flit_valid && flit_ready;
    assign head = mem_q[rd_ptr_q];
    assign flit_data = flit_valid ? head[FLIT_SIZE-1:0] : '0;
    assign flit_sop = flit_valid && head[EW-1];
    assign flit_eop = flit_valid && head[EW-2];
    assign phy_word_ready = ready_q;
    assign lng_error = lng_err_q;
    assign fifo_overflow = ovf_q;
    assign count_d = count_q + push_cnt - CW'(pop);

    // Classify the flits of an accepted word in order; FSM state chains flit to flit,
    // and each pushed flit gets a compacted FIFO slot offset.
    always_comb begin : classify
        logic [FLIT_SIZE-1:0] f;
        logic [3:0]           lng;
        state_d   = state_q;
        rem_d     = rem_q;
        lng_err_d = lng_err_q;
        push_cnt  = '0;
        push_en   = '0;
        ent_sop   = '0;
        ent_eop   = '0;
        f         = '0;
        lng       = '0;
`ifdef HMC_TX_UNPACK_STATS_EN
        null_cnt  = '0;
        sop_cnt   = '0;
`endif
        for (int unsigned i = 0; i < FPW; i++) begin
            slot[i] = push_cnt[PW-1:0];
            if (accept) begin
                f   = phy_data_tx_link2phy[i*FLIT_SIZE +: FLIT_SIZE];
                lng = f[10:7];
                if (state_d == HDR) begin
                    if (f == '0) begin
`ifdef HMC_TX_UNPACK_STATS_EN
                        null_cnt = null_cnt + CW'(1);
`endif
                    end else begin
                        push_en[i] = 1'b1;
                        ent_sop[i] = 1'b1;
                        if (lng >= 4'd2 && lng <= 4'd9) begin
                            rem_d   = lng - 4'd1;
                            state_d = BODY;
                        end else begin
                            ent_eop[i] = 1'b1;
                            if (lng != 4'd1) lng_err_d = 1'b1;
                        end
`ifdef HMC_TX_UNPACK_STATS_EN
                        sop_cnt = sop_cnt + CW'(1);
`endif
                    end
                end else begin
                    push_en[i] = 1'b1;
                    rem_d = rem_d - 4'd1;
                    if (rem_d == 4'd0) begin
                        ent_eop[i] = 1'b1;
                        state_d    = HDR;
                    end
                end
                if (push_en[i]) push_cnt = push_cnt + CW'(1);
            end
        end
    end

    // Control state, FIFO pointers/occupancy, registered ready and sticky flags.
    always_ff @(posedge clk) begin
        if (!res_n) begin
            state_q   <= HDR;
            rem_q     <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            ready_q   <= 1'b1;
            lng_err_q <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            rem_q     <= rem_d;
            wr_ptr_q  <= wr_ptr_q + push_cnt[PW-1:0];
            rd_ptr_q  <= rd_ptr_q + PW'(pop);
            count_q   <= count_d;
            ready_q   <= (CW'(FIFO_DEPTH) - count_d) >= CW'(FPW);
            lng_err_q <= lng_err_d;
            if (phy_word_valid && !ready_q) ovf_q <= 1'b1;
        end
    end

    // FIFO storage write; contents need no reset since occupancy gates the outputs.
    always_ff @(posedge clk) begin
        for (int unsigned i = 0; i < FPW; i++) begin
            if (push_en[i])
                mem_q[wr_ptr_q + slot[i]] <=
                    {ent_sop[i], ent_eop[i], phy_data_tx_link2phy[i*FLIT_SIZE +: FLIT_SIZE]};
        end
    end

`ifdef HMC_TX_UNPACK_STATS_EN
    // Packet and NULL-flit statistics, wrapping at 2^32.
    always_ff @(posedge clk) begin
        if (!res_n) begin
            pkt_count_q  <= '0;
            null_count_q <= '0;
        end else begin
            pkt_count_q  <= pkt_count_q + 32'(sop_cnt);
            null_count_q <= null_count_q + 32'(null_cnt);
        end
    end

    assign pkt_count  = pkt_count_q;
    assign null_count = null_count_q;
`endif

endmodule
